// File: rtl/multi_button_shaper.sv
// Per-channel debouncer/pulse shaper for active-low buttons: 2-flop sync, 5-state FSM, one-cycle press pulse.
// Optional auto-repeat while held is enabled by defining MULTI_BUTTON_SHAPER_REPEAT_EN.
module multi_button_shaper #(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned DEB_CYCLES    = 16,
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 250
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [N_CH-1:0] ButtonIn,
  output logic [N_CH-1:0] PulseOut,
  output logic [N_CH-1:0] Pressed
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
`ifdef MULTI_BUTTON_SHAPER_REPEAT_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_Idle     = 3'd0,
    S_PressDeb = 3'd1,
    S_Pulse    = 3'd2,
    S_Held     = 3'd3,
    S_RelDeb   = 3'd4
  } state_t;

  // Reject out-of-range configurations at elaboration.
  if (N_CH < 1 || N_CH > 16 || DEB_CYCLES < 2 || DEB_CYCLES > 65535 ||
      HOLD_CYCLES < 2 || HOLD_CYCLES > 65535 ||
      REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_param
    $error("multi_button_shaper: parameter out of range");
  end

  logic [N_CH-1:0] r_meta;
  logic [N_CH-1:0] r_sync;
  state_t          r_state     [N_CH];
  state_t          w_state_nxt [N_CH];
  logic [CW-1:0]   r_cnt       [N_CH];
  logic [CW-1:0]   w_cnt_nxt   [N_CH];
  logic [N_CH-1:0] r_pulse;
  logic [N_CH-1:0] r_pressed;
`ifdef MULTI_BUTTON_SHAPER_REPEAT_EN
  logic [N_CH-1:0] r_rep;
  logic [N_CH-1:0] w_rep_nxt;
`endif

  // Next-state logic; each channel is evaluated independently.
  always_comb begin
`ifdef MULTI_BUTTON_SHAPER_REPEAT_EN
    w_rep_nxt = r_rep;
`endif
    for (int i = 0; i < int'(N_CH); i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        S_Idle: begin
          if (!r_sync[i]) begin
            w_state_nxt[i] = S_PressDeb;
            w_cnt_nxt[i]   = CW'(1);
          end
        end
        S_PressDeb: begin
          if (r_sync[i]) begin
            w_state_nxt[i] = S_Idle;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == DEB_LAST) begin
            w_state_nxt[i] = S_Pulse;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CW'(1);
          end
        end
        S_Pulse: begin
          w_state_nxt[i] = S_Held;
          w_cnt_nxt[i]   = '0;
        end
        S_Held: begin
          if (r_sync[i]) begin
            w_state_nxt[i] = S_RelDeb;
            w_cnt_nxt[i]   = CW'(1);
          end else begin
`ifdef MULTI_BUTTON_SHAPER_REPEAT_EN
            if ((!r_rep[i] && r_cnt[i] == HOLD_LAST) || (r_rep[i] && r_cnt[i] == REP_LAST)) begin
              w_state_nxt[i] = S_Pulse;
              w_cnt_nxt[i]   = '0;
              w_rep_nxt[i]   = 1'b1;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            end
`else
            w_cnt_nxt[i] = '0;
`endif
          end
        end
        S_RelDeb: begin
          if (!r_sync[i]) begin
            w_state_nxt[i] = S_Held;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == DEB_LAST) begin
            w_state_nxt[i] = S_Idle;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CW'(1);
          end
        end
        default: begin
          w_state_nxt[i] = S_Idle;
          w_cnt_nxt[i]   = '0;
        end
      endcase
`ifdef MULTI_BUTTON_SHAPER_REPEAT_EN
      if (w_state_nxt[i] == S_Idle) begin
        w_rep_nxt[i] = 1'b0;
      end
`endif
    end
  end

  // Synchroniser, state/counter registers and outputs registered from next state.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_meta    <= '1;
      r_sync    <= '1;
      r_pulse   <= '0;
      r_pressed <= '0;
`ifdef MULTI_BUTTON_SHAPER_REPEAT_EN
      r_rep     <= '0;
`endif
      for (int i = 0; i < int'(N_CH); i++) begin
        r_state[i] <= S_Idle;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_meta <= ButtonIn;
      r_sync <= r_meta;
`ifdef MULTI_BUTTON_SHAPER_REPEAT_EN
      r_rep  <= w_rep_nxt;
`endif
      for (int i = 0; i < int'(N_CH); i++) begin
        r_state[i]   <= w_state_nxt[i];
        r_cnt[i]     <= w_cnt_nxt[i];
        r_pulse[i]   <= (w_state_nxt[i] == S_Pulse);
        r_pressed[i] <= (w_state_nxt[i] == S_Pulse) || (w_state_nxt[i] == S_Held) ||
                        (w_state_nxt[i] == S_RelDeb);
      end
    end
  end

  assign PulseOut = r_pulse;
  assign Pressed  = r_pressed;

endmodule

// File: doc/multi_button_shaper.md
MULTI_BUTTON_SHAPER -- requirements
Module: multi_button_shaper

Interface
REQ-001 Parameter N_CH, default 4, number of independent active-low button channels (1..16).
REQ-002 Parameter DEB_CYCLES, default 16, consecutive stable cycles needed to accept a press or a release (2..65535).
REQ-003 Parameter HOLD_CYCLES, default 1000, cycles in Held before the first auto-repeat pulse (2..65535; used only with REPEAT_EN).
REQ-004 Parameter REPEAT_CYCLES, default 250, cycles between later auto-repeat pulses (2..65535; used only with REPEAT_EN).
REQ-005 Clk  input  1  single clock; all state updates on rising edge.
REQ-006 Reset  input  1  synchronous, active-low reset, sampled on rising edge of Clk.
REQ-007 ButtonIn  input  N_CH  raw asynchronous button levels, active-low (0 = pressed).
REQ-008 PulseOut  output  N_CH  one-cycle high pulse per accepted press (and per repeat), per channel.
REQ-009 Pressed  output  N_CH  debounced level, high while the channel is accepted as pressed.

Function
REQ-010 Each ButtonIn bit SHALL pass through a 2-flop synchroniser; the FSM SHALL see only the second flop (sync).
REQ-011 Each channel SHALL have its own FSM and 16-bit counter, fully independent of the other channels.
REQ-012 States SHALL be S_Idle, S_PressDeb, S_Pulse, S_Held, S_RelDeb.
REQ-013 S_Idle: sync=0 -> S_PressDeb, counter=1; otherwise stay.
REQ-014 S_PressDeb: sync=1 -> S_Idle with no pulse; sync=0 and counter=DEB_CYCLES-1 -> S_Pulse; else counter+1.
REQ-015 S_Pulse SHALL last exactly one cycle, then -> S_Held, counter=0.
REQ-016 S_Held: sync=1 -> S_RelDeb, counter=1; else stay, with counter behaviour as in REQ-027.
REQ-017 S_RelDeb: sync=0 -> S_Held, counter=0; sync=1 and counter=DEB_CYCLES-1 -> S_Idle; else counter+1.
REQ-018 PulseOut[i] SHALL be high only in S_Pulse; Pressed[i] SHALL be high in S_Pulse, S_Held and S_RelDeb.
REQ-019 Both outputs SHALL be decoded from registered state only, with no combinational path from ButtonIn.
REQ-020 Latency: if edge k first samples ButtonIn[i]=0 and it stays low, PulseOut[i] SHALL be high for exactly the cycle after edge k+DEB_CYCLES+1.
REQ-021 A glitch shorter than DEB_CYCLES SHALL produce no pulse and no change on Pressed.
REQ-022 A press held for any length SHALL produce exactly one pulse without REPEAT_EN.
REQ-023 An illegal state encoding SHALL go to S_Idle on the next edge.
REQ-024 Counters SHALL never wrap; every terminal compare leaves its state before overflow.

Reset
REQ-025 With Reset=0 at an edge, every channel SHALL go to S_Idle, and counters and synchroniser flops SHALL be set (sync flops to 1). PulseOut=0 and Pressed=0 from the next cycle.
REQ-026 Reset during S_PressDeb, S_Pulse or S_Held SHALL abort the press with no further pulse. A button still held at release of Reset SHALL be debounced again as a new press.

Configuration
REQ-027 Macro MULTI_BUTTON_SHAPER_REPEAT_EN:
- Defined: S_Held counts cycles; at counter=HOLD_CYCLES-1 -> S_Pulse and arm repeat mode. Each later S_Held period goes to S_Pulse at counter=REPEAT_CYCLES-1. Repeat mode clears on entry to S_Idle. A release bounce back into S_Held keeps repeat mode, and counting restarts from 0.
- Undefined: S_Held counter holds at 0 and there is no repeat logic; HOLD_CYCLES and REPEAT_CYCLES are ignored.

Verification
REQ-028 DEB_CYCLES=4. Ch0 driven low at edge 10, held 50 cycles -> PulseOut[0] high only in the cycle after edge 15; Pressed[0] rises with it.
REQ-029 DEB_CYCLES=4. Ch1 low for 3 cycles, high 1 cycle, repeated 10 times -> PulseOut[1]=0 and Pressed[1]=0 throughout.
REQ-030 DEB_CYCLES=4. All 4 channels pressed on the same edge -> all PulseOut bits pulse in the same cycle, exactly once each.
REQ-031 DEB_CYCLES=4. Ch2 held, then released with a 2-cycle high bounce, then held again -> no second pulse; Pressed[2] stays high.
REQ-032 DEB_CYCLES=4. Reset=0 for 1 cycle in the cycle before the expected pulse -> no pulse; Pressed=0. After Reset=1 with the button still low, one pulse follows 6 edges later.
REQ-033 REPEAT_EN defined, DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, ch3 held 60 cycles after the first pulse -> pulses at +0, +21, +30, +39, +48, +57 cycles.
